// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: one-entry sample buffer feeding a 64-bclk frame (two 32-bit slots, mono).
// Samples are sent MSB first with the standard one-bit delay. G_DWIDTH must be 1..31.
module i2s_tx_serializer #(
    parameter int unsigned G_DWIDTH   = 24,
    parameter int unsigned G_BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [G_DWIDTH-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underflow,
    output logic [15:0]         underflow_count
);

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = 6;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SLOT_W = 32;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                sdata_q, sdata_d;
    logic                din_ready_q, din_ready_d;
    logic                underflow_q, underflow_d;
    logic [CNT_W-1:0]    uf_cnt_q, uf_cnt_d;
    logic [G_DWIDTH-1:0] buf_q, buf_d;
    logic                buf_full_q, buf_full_d;
    logic [G_DWIDTH-1:0] shift_q, shift_d;

    logic                accept;
    logic                wrap;
    logic                fall;
    logic [SLOT_W-1:0]   slot_w;

    // Next-state logic: IDLE clears the datapath, RUN advances the bit clock and frame.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        din_ready_d = din_ready_q;
        underflow_d = 1'b0;
        uf_cnt_d    = uf_cnt_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        shift_d     = shift_q;
        accept      = 1'b0;
        wrap        = 1'b0;
        fall        = 1'b0;
        slot_w      = '0;

        if (!enable) begin
            state_d     = ST_IDLE;
            div_cnt_d   = '0;
            bit_cnt_d   = '0;
            bclk_d      = 1'b0;
            lrclk_d     = 1'b0;
            sdata_d     = 1'b0;
            din_ready_d = 1'b0;
            buf_d       = '0;
            buf_full_d  = 1'b0;
            shift_d     = '0;
        end else if (state_q == ST_IDLE) begin
            state_d     = ST_RUN;
            din_ready_d = 1'b1;
        end else begin
            accept    = din_valid && din_ready_q;
            wrap      = (div_cnt_q == DIV_W'(G_BCLK_DIV - 1));
            fall      = wrap && bclk_q;
            div_cnt_d = wrap ? '0 : div_cnt_q + 8'd1;
            if (wrap) begin
                bclk_d = ~bclk_q;
            end
            if (fall) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                // Frame boundary: a starved frame is decided before a same-cycle accept lands.
                if (bit_cnt_q == '1) begin
                    if (buf_full_q) begin
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
                    end else begin
                        shift_d     = '0;
                        underflow_d = 1'b1;
                        if (uf_cnt_q != '1) begin
                            uf_cnt_d = uf_cnt_q + 16'd1;
                        end
                    end
                end
                slot_w[SLOT_W-2 -: G_DWIDTH] = shift_d;
                lrclk_d = bit_cnt_d[BIT_W-1];
                sdata_d = slot_w[5'(SLOT_W - 1) - bit_cnt_d[4:0]];
            end
            if (accept) begin
                buf_d      = din;
                buf_full_d = 1'b1;
            end
            din_ready_d = !buf_full_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            din_ready_q <= 1'b0;
            underflow_q <= 1'b0;
            uf_cnt_q    <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            din_ready_q <= din_ready_d;
            underflow_q <= underflow_d;
            uf_cnt_q    <= uf_cnt_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            shift_q     <= shift_d;
        end
    end

    assign din_ready       = din_ready_q;
    assign bclk            = bclk_q;
    assign lrclk           = lrclk_q;
    assign sdata           = sdata_q;
    assign underflow       = underflow_q;
    assign underflow_count = uf_cnt_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: directed scenarios with random samples, every cycle checked
// against a frame-arithmetic model (cycle count since RUN start -> bclk, bit, slot, sample).
module tb_i2s_tx_serializer;

    localparam int DW    = 24;
    localparam int DIV   = 4;
    localparam int FRAME = 2 * DIV * 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready, bclk, lrclk, sdata, underflow;
    logic [15:0]   underflow_count;

    int vectors = 0;
    int miscompares = 0;

    // Model state: m_n counts RUN cycles since entering RUN; m_cur is the sample of the current frame.
    bit            m_run = 0;
    int            m_n = 0;
    bit            m_full = 0;
    logic [DW-1:0] m_buf = '0;
    logic [DW-1:0] m_cur = '0;
    bit            m_ready = 0;
    bit            m_uf = 0;
    int            m_cnt = 0;

    i2s_tx_serializer #(.G_DWIDTH(DW), .G_BCLK_DIV(DIV)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .din             (din),
        .din_valid       (din_valid),
        .din_ready       (din_ready),
        .bclk            (bclk),
        .lrclk           (lrclk),
        .sdata           (sdata),
        .underflow       (underflow),
        .underflow_count (underflow_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h (t=%0t n=%0d)", tag, obs, exp, $time, m_n);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_n = 0; m_full = 0; m_buf = '0; m_cur = '0;
        m_ready = 0; m_uf = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit acc;
        if (!reset) begin
            model_reset();
        end else if (!enable) begin
            m_run = 0; m_n = 0; m_full = 0; m_cur = '0; m_ready = 0; m_uf = 0;
        end else if (!m_run) begin
            m_run = 1; m_n = 0; m_ready = 1; m_uf = 0;
        end else begin
            acc  = din_valid && m_ready;
            m_n  = m_n + 1;
            m_uf = 0;
            if (m_n % FRAME == 0) begin
                if (m_full) begin
                    m_cur  = m_buf;
                    m_full = 0;
                end else begin
                    m_cur = '0;
                    m_uf  = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (acc) begin
                m_buf  = din;
                m_full = 1;
            end
            m_ready = !m_full;
        end
    endtask

    task automatic check_all();
        int bc, b, e_sd;
        bc   = (m_n / (2 * DIV)) % 64;
        b    = bc % 32;
        e_sd = (b >= 1 && b <= DW) ? int'((m_cur >> (DW - b)) & 1) : 0;
        chk("bclk", int'(bclk), (m_n / DIV) % 2);
        chk("lrclk", int'(lrclk), bc / 32);
        chk("sdata", int'(sdata), e_sd);
        chk("din_ready", int'(din_ready), int'(m_ready));
        chk("underflow", int'(underflow), int'(m_uf));
        chk("underflow_count", int'(underflow_count), m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // mode 0: hold inputs; 1: valid high, fresh random din each cycle; 2: random valid and din
    task automatic run(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            if (mode == 1) begin
                din_valid = 1'b1;
                din = DW'($urandom);
            end else if (mode == 2) begin
                din_valid = ($urandom_range(0, 3) == 0);
                din = DW'($urandom);
            end
            tick();
        end
    endtask

    initial begin
        int guard;
        // Asynchronous reset with no clock edge in between.
        #2 reset = 1'b0;
        model_reset();
        #1 check_all();
        run(3, 0);
        #2 reset = 1'b1;

        // Fixed sample 0x800001 held valid: 1,0..0,1 pattern in both slots.
        enable = 1'b1;
        din = 24'h800001;
        din_valid = 1'b1;
        run(3 * FRAME, 0);

        // Fresh value every cycle with valid held: one accept per frame, no underflow.
        run(4 * FRAME, 1);

        // Starve: the pending buffer drains, then three starved frames.
        din_valid = 1'b0;
        run(4 * FRAME, 0);

        // Valid exactly on the 63->0 wrap cycle with an empty buffer.
        guard = 0;
        while (((m_n + 1) % FRAME) != 0 && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        chk("wrap_search_timeout", guard < 2 * FRAME ? 1 : 0, 1);
        din_valid = 1'b1;
        din = DW'($urandom);
        tick();
        din_valid = 1'b0;
        run(2 * FRAME, 0);

        // Random traffic.
        run(3 * FRAME, 2);

        // Enable dropped at bit_cnt=40, then re-enabled.
        guard = 0;
        while (((m_n / (2 * DIV)) % 64) != 40 && guard < 2 * FRAME) begin
            din_valid = 1'b1;
            din = DW'($urandom);
            tick();
            guard++;
        end
        chk("bit40_search_timeout", guard < 2 * FRAME ? 1 : 0, 1);
        enable = 1'b0;
        run($urandom_range(1, 20), 1);
        enable = 1'b1;
        run(3 * FRAME, 2);

        // Asynchronous reset mid-frame.
        run(FRAME / 2 + int'($urandom_range(0, 100)), 0);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all();
        run(2, 0);
        #2 reset = 1'b1;
        run(2 * FRAME, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
